// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, captures the instruction word into the fetch/decode register,
// and handles stall, branch, call/return through a small circular return-address stack, and halt.
module instr_fetch_unit #(
    parameter int          PROG_CTR_WID = 10,
    parameter int          RAS_DEPTH    = 4,
    parameter logic [15:0] HALT_INSTR   = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [PROG_CTR_WID-1:0] branch_target,
    input  logic                    call_en,
    input  logic [PROG_CTR_WID-1:0] call_target,
    input  logic                    ret_en,
    input  logic [15:0]             instr_mem_out,
    output logic [PROG_CTR_WID-1:0] prog_ctr,
    output logic [15:0]             if_instr,
    output logic [PROG_CTR_WID-1:0] if_pc,
    output logic                    if_valid,
    output logic                    halted,
    output logic                    ras_overflow,
    output logic                    ras_underflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PROG_CTR_WID-1:0] PC_ONE   = {{(PROG_CTR_WID-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]        PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(RAS_DEPTH);

    // ras_ptr is the next write slot; the top of stack sits one below it.
    logic [PROG_CTR_WID-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]        ras_ptr;
    logic [CNT_W-1:0]        ras_cnt;
    logic [PTR_W-1:0]        top_idx;
    logic                    ras_full;
    logic                    ras_empty;
    logic                    halt_seen;

    assign top_idx   = ras_ptr - PTR_ONE;
    assign ras_full  = (ras_cnt == CNT_FULL);
    assign ras_empty = (ras_cnt == '0);
    assign halt_seen = if_valid && (if_instr == HALT_INSTR) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_ctr      <= '0;
            if_instr      <= '0;
            if_pc         <= '0;
            if_valid      <= 1'b0;
            halted        <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            ras_ptr       <= '0;
            ras_cnt       <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (halted) begin
            // frozen until reset
        end else if (halt_seen) begin
            // keep the halt word visible to decode; nothing else advances
            halted <= 1'b1;
        end else if (if_valid && ret_en) begin
            if (ras_empty) begin
                prog_ctr      <= '0;
                ras_underflow <= 1'b1;
            end else begin
                prog_ctr <= ras_mem[top_idx];
                ras_ptr  <= top_idx;
                ras_cnt  <= ras_cnt - CNT_ONE;
            end
            if_valid <= 1'b0;
            if_instr <= '0;
        end else if (if_valid && call_en) begin
            // a full stack overwrites its oldest slot, which is the one at ras_ptr
            ras_mem[ras_ptr] <= if_pc + PC_ONE;
            ras_ptr          <= ras_ptr + PTR_ONE;
            if (ras_full) ras_overflow <= 1'b1;
            else          ras_cnt      <= ras_cnt + CNT_ONE;
            prog_ctr <= call_target;
            if_valid <= 1'b0;
            if_instr <= '0;
        end else if (if_valid && branch_taken) begin
            prog_ctr <= branch_target;
            if_valid <= 1'b0;
            if_instr <= '0;
        end else if (!stall) begin
            if_instr <= instr_mem_out;
            if_pc    <= prog_ctr;
            if_valid <= 1'b1;
            prog_ctr <= prog_ctr + PC_ONE;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [9:0]  branch_target = '0;
    logic        call_en = 1'b0;
    logic [9:0]  call_target = '0;
    logic        ret_en = 1'b0;
    logic [15:0] instr_mem_out;
    logic [9:0]  prog_ctr;
    logic [15:0] if_instr;
    logic [9:0]  if_pc;
    logic        if_valid;
    logic        halted;
    logic        ras_overflow;
    logic        ras_underflow;

    logic [15:0] mem [1024];
    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.PROG_CTR_WID(10), .RAS_DEPTH(4), .HALT_INSTR(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .call_en(call_en), .call_target(call_target), .ret_en(ret_en),
        .instr_mem_out(instr_mem_out), .prog_ctr(prog_ctr), .if_instr(if_instr),
        .if_pc(if_pc), .if_valid(if_valid), .halted(halted),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;
    assign instr_mem_out = mem[prog_ctr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stack is a plain queue whose back is the top.
    int m_pc, m_ifpc, m_instr, m_v, m_halt, m_of, m_uf;
    int ras_q[$];
    int tmp;
    initial begin
        m_pc = 0; m_ifpc = 0; m_instr = 0; m_v = 0; m_halt = 0; m_of = 0; m_uf = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_ifpc = 0; m_instr = 0; m_v = 0; m_halt = 0; m_of = 0; m_uf = 0;
            ras_q.delete();
        end else if (m_halt == 0) begin
            if (m_v == 1 && m_instr == 16'hFFFF && !stall) begin
                m_halt = 1;
            end else if (m_v == 1 && (ret_en || call_en || branch_taken)) begin
                if (ret_en) begin
                    if (ras_q.size() == 0) begin m_pc = 0; m_uf = 1; end
                    else m_pc = ras_q.pop_back();
                end else if (call_en) begin
                    ras_q.push_back((m_ifpc + 1) % 1024);
                    if (ras_q.size() > 4) begin tmp = ras_q.pop_front(); m_of = 1; end
                    m_pc = int'(call_target);
                end else begin
                    m_pc = int'(branch_target);
                end
                m_v = 0;
                m_instr = 0;
            end else if (!stall) begin
                m_instr = int'(mem[m_pc]);
                m_ifpc = m_pc;
                m_v = 1;
                m_pc = (m_pc + 1) % 1024;
            end
        end
    end

    always @(negedge clk) begin
        chk("prog_ctr", 32'(prog_ctr), m_pc);
        chk("if_instr", 32'(if_instr), m_instr);
        chk("if_pc", 32'(if_pc), m_ifpc);
        chk("if_valid", 32'(if_valid), m_v);
        chk("halted", 32'(halted), m_halt);
        chk("ras_overflow", 32'(ras_overflow), m_of);
        chk("ras_underflow", 32'(ras_underflow), m_uf);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_branch(input logic [9:0] t);
        branch_taken = 1'b1; branch_target = t;
        tick();
        branch_taken = 1'b0;
        tick();
    endtask

    task automatic do_call(input logic [9:0] t);
        call_en = 1'b1; call_target = t;
        tick();
        call_en = 1'b0;
        tick();
    endtask

    task automatic do_ret();
        ret_en = 1'b1;
        tick();
        ret_en = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
        mem[10'h3FF] = 16'hFFFF;
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_pc", 32'(prog_ctr), 0);
        chk("rst_valid", 32'(if_valid), 0);
        rst_n = 1'b1;

        // straight-line fetch
        tick();
        chk("first_instr", 32'(if_instr), 32'h1000);
        chk("first_valid", 32'(if_valid), 1);
        chk("first_pc", 32'(prog_ctr), 1);
        tick(); tick();
        chk("seq_ifpc", 32'(if_pc), 2);
        chk("seq_instr", 32'(if_instr), 32'h1002);

        // stall, then branch overriding stall
        stall = 1'b1;
        tick(); tick(); tick();
        chk("stall_pc", 32'(prog_ctr), 3);
        chk("stall_instr", 32'(if_instr), 32'h1002);
        branch_taken = 1'b1; branch_target = 10'h040;
        tick();
        chk("br_pc", 32'(prog_ctr), 32'h040);
        chk("br_bubble", 32'(if_valid), 0);
        chk("br_ifpc_hold", 32'(if_pc), 2);
        branch_taken = 1'b0; stall = 1'b0;
        tick();
        chk("br_ifpc", 32'(if_pc), 32'h040);
        chk("br_instr", 32'(if_instr), 32'h1040);

        // nested call/ret
        do_branch(10'h005);
        chk("at5", 32'(if_pc), 5);
        do_call(10'h100);
        tick(); tick();
        chk("at102", 32'(if_pc), 32'h102);
        do_call(10'h200);
        do_ret();
        chk("ret103", 32'(if_pc), 32'h103);
        do_ret();
        chk("ret6", 32'(if_pc), 6);
        chk("no_of", 32'(ras_overflow), 0);
        chk("no_uf", 32'(ras_underflow), 0);

        // overflow: pushes 7,301,311,321,331; 7 is lost
        do_call(10'h300); do_call(10'h310); do_call(10'h320); do_call(10'h330); do_call(10'h340);
        chk("of_set", 32'(ras_overflow), 1);
        // call+ret together: ret wins, no push
        call_en = 1'b1; ret_en = 1'b1; call_target = 10'h3A0;
        tick();
        call_en = 1'b0; ret_en = 1'b0;
        tick();
        chk("callret", 32'(if_pc), 32'h331);
        do_ret();
        chk("ret321", 32'(if_pc), 32'h321);
        do_ret(); do_ret();
        chk("ret301", 32'(if_pc), 32'h301);
        chk("uf_clear", 32'(ras_underflow), 0);
        ret_en = 1'b1;
        tick();
        ret_en = 1'b0;
        chk("uf_pc", 32'(prog_ctr), 0);
        chk("uf_set", 32'(ras_underflow), 1);
        tick();

        // wrap and halt
        do_branch(10'h3FF);
        chk("wrap_pc", 32'(prog_ctr), 0);
        chk("halt_word", 32'(if_instr), 32'hFFFF);
        chk("not_yet_halted", 32'(halted), 0);
        tick();
        chk("halted", 32'(halted), 1);
        for (int i = 0; i < 10; i++) begin
            branch_taken = i[0]; branch_target = 10'h055; call_en = i[1]; ret_en = i[2];
            tick();
            chk("halt_pc", 32'(prog_ctr), 0);
        end
        branch_taken = 1'b0; call_en = 1'b0; ret_en = 1'b0;
        chk("halt_valid", 32'(if_valid), 1);

        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", 32'(prog_ctr), 0);
        chk("arst_halt", 32'(halted), 0);
        chk("arst_instr", 32'(if_instr), 0);
        chk("arst_valid", 32'(if_valid), 0);
        chk("arst_of", 32'(ras_overflow), 0);
        chk("arst_uf", 32'(ras_underflow), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_instr", 32'(if_instr), 32'h1000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
